// File: rtl/k423_div_ctrl.sv
// Multi-cycle RV32M divide sequencer: radix-2 restoring divider with pipeline stall,
// branch-flush abort and a one-cycle result pulse aligned to stall release.
module k423_div_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_div_vld_i,
    input  logic [1:0]      ex_div_op_i,
    input  logic [XLEN-1:0] ex_div_src1_i,
    input  logic [XLEN-1:0] ex_div_src2_i,
    input  logic [4:0]      ex_div_rd_idx_i,
    input  logic            pcu_flush_br_i,
    output logic            div_stall_o,
    output logic            div_busy_o,
    output logic            div_done_o,
    output logic [XLEN-1:0] div_res_o,
    output logic [4:0]      div_rd_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [XLEN-1:0] rem_reg, rem_next;
    logic [XLEN-1:0] quo_reg, quo_next;
    logic [XLEN-1:0] dvs_reg, dvs_next;
    logic [XLEN-1:0] res_reg, res_next;
    logic [1:0]      op_reg, op_next;
    logic [4:0]      rd_reg, rd_next;
    logic [4:0]      rd_out_reg, rd_out_next;
    logic            sign1_reg, sign1_next;
    logic            sign2_reg, sign2_next;
    logic            done_reg, done_next;

    // Operand conditioning for the accept cycle
    logic            in_signed, in_rem, in_neg1, in_neg2;
    logic            in_div_zero, in_ovf, in_special, accept;
    logic [XLEN-1:0] in_abs1, in_abs2, in_special_res;

    assign in_signed   = ~ex_div_op_i[0];
    assign in_rem      = ex_div_op_i[1];
    assign in_neg1     = in_signed & ex_div_src1_i[XLEN-1];
    assign in_neg2     = in_signed & ex_div_src2_i[XLEN-1];
    assign in_abs1     = in_neg1 ? (~ex_div_src1_i + 1'b1) : ex_div_src1_i;
    assign in_abs2     = in_neg2 ? (~ex_div_src2_i + 1'b1) : ex_div_src2_i;
    assign in_div_zero = (ex_div_src2_i == '0);
    assign in_ovf      = in_signed && (ex_div_src1_i == MIN_NEG) && (ex_div_src2_i == '1);
    assign in_special  = in_div_zero | in_ovf;
    assign accept      = (state_reg == S_IDLE) & ex_div_vld_i & ~pcu_flush_br_i;

    always_comb begin
        in_special_res = '0;
        if (in_div_zero) begin
            in_special_res = in_rem ? ex_div_src1_i : '1;
        end else begin
            in_special_res = in_rem ? '0 : ex_div_src1_i;
        end
    end

    // One restoring step: the extra top bit of the trial difference is the borrow
    logic [XLEN:0]   step_shift, step_diff;
    logic            step_ok;
    logic [XLEN-1:0] fix_quo, fix_rem;

    assign step_shift = {rem_reg, quo_reg[XLEN-1]};
    assign step_diff  = step_shift - {1'b0, dvs_reg};
    assign step_ok    = ~step_diff[XLEN];
    assign fix_quo    = (sign1_reg ^ sign2_reg) ? (~quo_reg + 1'b1) : quo_reg;
    assign fix_rem    = sign1_reg ? (~rem_reg + 1'b1) : rem_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dvs_next    = dvs_reg;
        res_next    = res_reg;
        op_next     = op_reg;
        rd_next     = rd_reg;
        rd_out_next = rd_out_reg;
        sign1_next  = sign1_reg;
        sign2_next  = sign2_reg;
        done_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    op_next    = ex_div_op_i;
                    rd_next    = ex_div_rd_idx_i;
                    sign1_next = in_neg1;
                    sign2_next = in_neg2;
                    rem_next   = '0;
                    quo_next   = in_abs1;
                    dvs_next   = in_abs2;
                    if (in_special) begin
                        res_next    = in_special_res;
                        rd_out_next = ex_div_rd_idx_i;
                        done_next   = 1'b1;
                        state_next  = S_DONE;
                    end else begin
                        cnt_next   = CNT_W'(XLEN - 1);
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (step_ok) begin
                    rem_next = step_diff[XLEN-1:0];
                    quo_next = {quo_reg[XLEN-2:0], 1'b1};
                end else begin
                    rem_next = step_shift[XLEN-1:0];
                    quo_next = {quo_reg[XLEN-2:0], 1'b0};
                end
                if (cnt_reg == '0) begin
                    state_next = S_FIX;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_FIX: begin
                res_next    = op_reg[1] ? fix_rem : fix_quo;
                rd_out_next = rd_reg;
                done_next   = 1'b1;
                state_next  = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Flush wins over everything, including a result about to be published
        if (pcu_flush_br_i) begin
            state_next  = S_IDLE;
            cnt_next    = '0;
            done_next   = 1'b0;
            res_next    = res_reg;
            rd_out_next = rd_out_reg;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            res_reg    <= '0;
            op_reg     <= '0;
            rd_reg     <= '0;
            rd_out_reg <= '0;
            sign1_reg  <= 1'b0;
            sign2_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dvs_reg    <= dvs_next;
            res_reg    <= res_next;
            op_reg     <= op_next;
            rd_reg     <= rd_next;
            rd_out_reg <= rd_out_next;
            sign1_reg  <= sign1_next;
            sign2_reg  <= sign2_next;
            done_reg   <= done_next;
        end
    end

    assign div_stall_o  = ~rst_i & ~pcu_flush_br_i &
                          (((state_reg == S_IDLE) & ex_div_vld_i) |
                           (state_reg == S_CALC) | (state_reg == S_FIX));
    assign div_busy_o   = (state_reg != S_IDLE);
    assign div_done_o   = done_reg & ~pcu_flush_br_i;
    assign div_res_o    = res_reg;
    assign div_rd_idx_o = rd_out_reg;

endmodule

// File: tb/tb_k423_div_ctrl.sv
// Directed plus randomized checks of the divide sequencer against an arithmetic reference.
module tb_k423_div_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            vld;
    logic [1:0]      op;
    logic [XLEN-1:0] src1, src2;
    logic [4:0]      rd;
    logic            flush;
    logic            stall, busy, done;
    logic [XLEN-1:0] res;
    logic [4:0]      rd_out;

    int n_vec = 0;
    int n_err = 0;

    k423_div_ctrl #(.XLEN(XLEN)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ex_div_vld_i   (vld),
        .ex_div_op_i    (op),
        .ex_div_src1_i  (src1),
        .ex_div_src2_i  (src2),
        .ex_div_rd_idx_i(rd),
        .pcu_flush_br_i (flush),
        .div_stall_o    (stall),
        .div_busy_o     (busy),
        .div_done_o     (done),
        .div_res_o      (res),
        .div_rd_idx_o   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics straight from the arithmetic definition
    function automatic logic [XLEN-1:0] ref_res(input logic [1:0] o, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : '1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
        case (o)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    step_tick_dummy_t_unused_guard: assert property (@(posedge clk) 1'b1);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered just after a negedge; leaves one cycle past the done cycle with the op still driven
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] r);
        logic [XLEN-1:0] exp_res;
        int lat;
        exp_res = ref_res(o, a, b);
        lat     = ref_lat(o, a, b);
        vld  = 1'b1;
        op   = o;
        src1 = a;
        src2 = b;
        rd   = r;
        #1;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) tick();
            check("stall", stall, (c < lat) ? 1 : 0);
            check("done",  done,  (c == lat) ? 1 : 0);
            check("busy",  busy,  (c > 0) ? 1 : 0);
        end
        check("res", res, exp_res);
        check("rd",  rd_out, r);
        $display("op=%0d a=%h b=%h rd=%0d -> res=%h exp=%h lat=%0d", o, a, b, r, res, exp_res, lat);
        tick();
        check("busy_after", busy, 0);
    endtask

    task automatic go_idle();
        vld = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0]      ro;
        logic [XLEN-1:0] ra, rb;

        rst = 1'b1; vld = 1'b0; op = '0; src1 = '0; src2 = '0; rd = '0; flush = 1'b0;
        tick();
        tick();
        check("rst_done",  done,   0);
        check("rst_res",   res,    0);
        check("rst_rd",    rd_out, 0);
        check("rst_busy",  busy,   0);
        check("rst_stall", stall,  0);
        rst = 1'b0;
        tick();

        run_op(2'd1, 100, 7, 5'd3);              go_idle();
        run_op(2'd3, 100, 7, 5'd4);              go_idle();
        run_op(2'd0, -32'sd7, 2, 5'd5);          go_idle();
        run_op(2'd2, -32'sd7, 2, 5'd6);          go_idle();
        run_op(2'd2, 7, -32'sd2, 5'd7);          go_idle();
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8); go_idle();
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); go_idle();
        run_op(2'd1, 5, 0, 5'd10);               go_idle();
        run_op(2'd3, 5, 0, 5'd11);               go_idle();
        run_op(2'd0, -32'sd5, 0, 5'd12);         go_idle();

        // Branch flush ten cycles into a long divide
        vld = 1'b1; op = 2'd1; src1 = 1000; src2 = 3; rd = 5'd13;
        for (int c = 0; c < 10; c++) tick();
        flush = 1'b1;
        #1;
        check("flush_stall", stall, 0);
        check("flush_done",  done,  0);
        tick();
        flush = 1'b0;
        check("flush_idle", busy, 0);
        check("flush_done2", done, 0);
        $display("flush at T+10 -> busy=%0d", busy);
        run_op(2'd1, 9, 3, 5'd14);               go_idle();

        // Reset mid-CALC
        vld = 1'b1; op = 2'd0; src1 = 12345; src2 = 17; rd = 5'd15;
        for (int c = 0; c < 20; c++) tick();
        rst = 1'b1;
        #1;
        check("arst_busy",  busy,  0);
        check("arst_stall", stall, 0);
        check("arst_done",  done,  0);
        tick();
        rst = 1'b0;
        vld = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            check("arst_nodone", done, 0);
        end
        $display("reset mid-CALC -> busy=%0d done=%0d", busy, done);

        // Back-to-back: second op presented the cycle after DONE
        run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd17);
        run_op(2'd2, -32'sd1000, 33, 5'd18);
        run_op(2'd1, 77, 0, 5'd19);
        go_idle();

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 500); rb = $urandom_range(1, 20); end
                3: rb = 32'($urandom_range(1, 7));
                default: ;
            endcase
            run_op(ro, ra, rb, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/k423_div_ctrl.md
Name: k423_div_ctrl

Overview:
- Sequencing controller for the multi-cycle integer divide path in EX (RV32M DIV/DIVU/REM/REMU).
- Accepts a divide op from EX, runs a radix-2 restoring iteration FSM over an internal remainder/quotient datapath, and holds the pipeline with a stall request to the pipeline control unit while busy.
- Aborts cleanly on a taken-branch flush.
- Returns the result with its rd index for one cycle, aligned to the release of the stall.

Parameters:
XLEN, 32, operand/result width
CNT_W, $clog2(XLEN), iteration counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
ex_div_vld_i  in  1  divide op present in EX (held stable by pipeline while div_stall_o=1)
ex_div_op_i  in  2  0=DIV 1=DIVU 2=REM 3=REMU
ex_div_src1_i  in  XLEN  dividend
ex_div_src2_i  in  XLEN  divisor
ex_div_rd_idx_i  in  5  destination register index
pcu_flush_br_i  in  1  taken-branch flush (abort)
div_stall_o  out  1  stall request to pipeline control unit
div_busy_o  out  1  FSM not IDLE
div_done_o  out  1  result valid, one-cycle pulse
div_res_o  out  XLEN  quotient or remainder
div_rd_idx_o  out  5  rd of completed op

Behaviour:
- Reset (async, rst_i=1): state=IDLE, counter=0, all datapath regs=0, div_done_o=0, div_res_o=0, div_rd_idx_o=0, div_busy_o=0.
  - div_stall_o=0 during reset.
- States: IDLE, CALC, FIX, DONE.
- IDLE, ex_div_vld_i=1, pcu_flush_br_i=0 (accept cycle T):
  - Latch op, rd, sign flags, |src1|, |src2|.
  - Absolute values only for DIV/REM; DIVU/REMU use raw operands.
  - Divisor==0 or (DIV/REM with src1=0x8000_0000, src2=0xFFFF_FFFF) -> DONE with special result.
  - Otherwise -> CALC, counter=XLEN-1.
- CALC: one restoring step per cycle.
  - Shift {rem,quo} left 1; trial subtract divisor; if non-negative, keep the difference and set quo[0]=1.
  - counter decrements; on counter==0 -> FIX.
  - Exactly XLEN cycles in CALC.
- FIX (1 cycle): apply signs for signed ops.
  - Quotient negated if sign1^sign2.
  - Remainder negated if sign1.
  - Select quo for DIV/DIVU, rem for REM/REMU. -> DONE.
- DONE (1 cycle): div_done_o=1, div_res_o/div_rd_idx_o valid. -> IDLE.
  - The op still visible on ex_div_vld_i this cycle must NOT be re-accepted.
- div_stall_o:
  - Combinational = (IDLE & ex_div_vld_i & ~pcu_flush_br_i) | CALC | FIX.
  - Deasserted in DONE so the instruction leaves EX with its result.
- Latency:
  - Normal op: stall for XLEN+2 cycles (T..T+XLEN+1), done at T+XLEN+2.
  - Special op: stall 1 cycle (T), done at T+1.
- Special results:
  - Div-by-zero: quotient=all ones, remainder=src1.
  - Signed overflow: quotient=src1 (0x8000_0000), remainder=0.
- div_busy_o = state!=IDLE.
- div_done_o is registered high only in DONE and 0 elsewhere.
- div_res_o/div_rd_idx_o hold their last value outside DONE.
- Flush:
  - pcu_flush_br_i=1 in any state forces next state IDLE and counter=0.
  - div_stall_o=0 and div_done_o=0 in that cycle (flush has priority over accept and over DONE).
  - Result is dropped; no done pulse for the aborted op.
- ex_div_vld_i in CALC/FIX is ignored (same held instruction).
- Async reset mid-operation: immediate return to IDLE, no done pulse.
- All arithmetic at XLEN+1 bits for the trial subtract; the result is truncated to XLEN.

Test Plan:
- DIVU 100/7 accepted at T -> div_stall_o=1 for T..T+33, div_done_o=1 at T+34, div_res_o=14; REMU same operands -> 2.
- DIV -7/2 -> result 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
- DIV 0x8000_0000/0xFFFF_FFFF -> stall at T only, done at T+1, res=0x8000_0000; REM same operands -> 0.
- DIVU 5/0 -> done at T+1, res=0xFFFF_FFFF; REMU 5/0 -> 5; DIV -5/0 -> 0xFFFF_FFFF.
- Start DIVU 1000/3, assert pcu_flush_br_i at T+10 -> div_stall_o=0 that cycle, state IDLE at T+11, no div_done_o pulse; new DIVU 9/3 at T+11 -> res 3 at T+45.
- Assert rst_i at T+20 mid-CALC -> div_busy_o=0 and div_stall_o=0 immediately, no done pulse; back-to-back ops (second op presented in the cycle after DONE) -> both results correct, rd indices preserved.
